// File: rtl/pulse_sync_pkg.sv
// Shared edge-mode encoding, parameter legality check and edge-select helper
// for the multi-channel pulse synchroniser.
package pulse_sync_pkg;

   typedef logic [1:0] edge_mode_t;

   localparam edge_mode_t EDGE_RISE = 2'd0;
   localparam edge_mode_t EDGE_FALL = 2'd1;
   localparam edge_mode_t EDGE_BOTH = 2'd2;

   function automatic bit params_legal(int channels, int sync_stages, int cnt_w, edge_mode_t mode);
      return (channels >= 1) && (sync_stages >= 2) && (cnt_w >= 1) && (mode <= EDGE_BOTH);
   endfunction

   function automatic logic edge_event(edge_mode_t mode, logic sync_v, logic prev_v);
      logic evt;
      case (mode)
         EDGE_FALL: evt = ~sync_v & prev_v;
         EDGE_BOTH: evt = sync_v ^ prev_v;
         default:   evt = sync_v & ~prev_v;
      endcase
      return evt;
   endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-bit flop synchroniser: each bit passes through STAGES flops into clk.
module sync_chain #(
   parameter int STAGES = 2,
   parameter int WIDTH  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] stage_q [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++) stage_q[s] <= '0;
      end else begin
         stage_q[0] <= async_i;
         for (int s = 1; s < STAGES; s++) stage_q[s] <= stage_q[s-1];
      end
   end

   assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/multi_channel_pulse_sync.sv
// Per-channel synchronise, edge-detect and queue events in a saturating
// counter, presented downstream as valid/ready with a sticky overflow flag.
module multi_channel_pulse_sync
   import pulse_sync_pkg::*;
#(
   parameter int         CHANNELS    = 4,
   parameter int         SYNC_STAGES = 2,
   parameter edge_mode_t EDGE_MODE   = EDGE_RISE,
   parameter int         CNT_W       = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] async_in,
   output logic [CHANNELS-1:0] evt_valid,
   input  logic [CHANNELS-1:0] evt_ready,
   output logic [CHANNELS-1:0] overflow,
   input  logic [CHANNELS-1:0] ovf_clr
);

   if (!params_legal(CHANNELS, SYNC_STAGES, CNT_W, EDGE_MODE)) begin : g_bad_params
      $error("multi_channel_pulse_sync: illegal parameter combination");
   end

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CHANNELS-1:0] sync_w;
   logic [CHANNELS-1:0] prev_q;

   sync_chain #(
      .STAGES (SYNC_STAGES),
      .WIDTH  (CHANNELS)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (async_in),
      .sync_o  (sync_w)
   );

   always_ff @(posedge clk) begin
      if (rst) prev_q <= '0;
      else     prev_q <= sync_w;
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             ovf_q, ovf_d;
      logic             event_w, accept_w;

      assign event_w  = edge_event(EDGE_MODE, sync_w[i], prev_q[i]);
      assign accept_w = evt_valid[i] & evt_ready[i];

      // An event arriving on a full counter is dropped and flagged; the flag
      // set takes priority over a clear in the same cycle.
      always_comb begin
         cnt_d = cnt_q;
         ovf_d = ovf_q & ~ovf_clr[i];
         if (event_w && !accept_w) begin
            if (cnt_q == CNT_MAX) ovf_d = 1'b1;
            else                  cnt_d = cnt_q + 1'b1;
         end else if (!event_w && accept_w) begin
            cnt_d = cnt_q - 1'b1;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
         end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
         end
      end

      assign evt_valid[i] = (cnt_q != '0);
      assign overflow[i]  = ovf_q;
   end

endmodule

// File: tb/tb_multi_channel_pulse_sync.sv
// Directed bench: default rise-mode instance, a toggle-mode instance and a
// three-stage single-channel toggle instance sharing one clock and reset.
module tb_multi_channel_pulse_sync;
   import pulse_sync_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] async_in, evt_ready, ovf_clr, evt_valid, overflow;
   logic [3:0] b_in, b_ready, b_clr, b_valid, b_ovf;
   logic [0:0] s_in, s_ready, s_clr, s_valid, s_ovf;

   int n_chk = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   multi_channel_pulse_sync #(.CHANNELS(4), .SYNC_STAGES(2), .EDGE_MODE(EDGE_RISE), .CNT_W(3)) dut (
      .clk(clk), .rst(rst), .async_in(async_in), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .overflow(overflow), .ovf_clr(ovf_clr));

   multi_channel_pulse_sync #(.CHANNELS(4), .SYNC_STAGES(2), .EDGE_MODE(EDGE_BOTH), .CNT_W(3)) dut_b (
      .clk(clk), .rst(rst), .async_in(b_in), .evt_valid(b_valid),
      .evt_ready(b_ready), .overflow(b_ovf), .ovf_clr(b_clr));

   multi_channel_pulse_sync #(.CHANNELS(1), .SYNC_STAGES(3), .EDGE_MODE(EDGE_BOTH), .CNT_W(3)) dut_s3 (
      .clk(clk), .rst(rst), .async_in(s_in), .evt_valid(s_valid),
      .evt_ready(s_ready), .overflow(s_ovf), .ovf_clr(s_clr));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic rise_edges(input int ch, input int n);
      for (int k = 0; k < n; k++) begin
         async_in[ch] = 1'b1;
         step(2);
         async_in[ch] = 1'b0;
         step(2);
      end
   endtask

   task automatic drain(input string tag, input int ch, input int n);
      evt_ready[ch] = 1'b1;
      for (int k = 0; k < n; k++) begin
         chk(tag, 32'(evt_valid[ch]), 32'd1);
         step();
      end
      chk({tag, "_empty"}, 32'(evt_valid[ch]), 32'd0);
      evt_ready[ch] = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      async_in = '0; evt_ready = '0; ovf_clr = '0;
      b_in = '0; b_ready = '0; b_clr = '0;
      s_in = '0; s_ready = '0; s_clr = '0;

      // Reset state and latency on ch0
      step();
      chk("rst_valid", 32'(evt_valid), 32'h0);
      chk("rst_ovf", 32'(overflow), 32'h0);
      step(2);
      chk("rst_valid3", 32'(evt_valid), 32'h0);
      rst = 1'b0;
      step();
      chk("idle_valid", 32'(evt_valid), 32'h0);
      async_in[0] = 1'b1;
      step();
      chk("lat_e0", 32'(evt_valid), 32'h0);
      step();
      chk("lat_e1", 32'(evt_valid), 32'h0);
      step();
      chk("lat_e2", 32'(evt_valid), 32'h1);
      drain("lat_drain", 0, 1);

      // Queueing on ch1
      rise_edges(1, 5);
      step();
      chk("q_other", 32'(evt_valid), 32'h2);
      drain("q_drain", 1, 5);

      // Overflow on ch2
      rise_edges(2, 9);
      chk("ovf_set", 32'(overflow), 32'h4);
      ovf_clr[2] = 1'b1;
      step();
      ovf_clr[2] = 1'b0;
      chk("ovf_clr", 32'(overflow[2]), 32'd0);
      async_in[2] = 1'b1;
      step(2);
      ovf_clr[2] = 1'b1;
      step();
      ovf_clr[2] = 1'b0;
      chk("ovf_set_wins", 32'(overflow[2]), 32'd1);
      async_in[2] = 1'b0;
      step(2);
      drain("ovf_drain", 2, 7);

      // Simultaneous event and accept at full on ch3
      rise_edges(3, 7);
      chk("sim_noovf0", 32'(overflow[3]), 32'd0);
      async_in[3] = 1'b1;
      step(2);
      evt_ready[3] = 1'b1;
      step();
      evt_ready[3] = 1'b0;
      chk("sim_noovf", 32'(overflow[3]), 32'd0);
      async_in[3] = 1'b0;
      step(2);
      drain("sim_drain", 3, 7);

      // Reset mid-operation on ch1 (cnt=4, overflow set)
      rise_edges(1, 8);
      evt_ready[1] = 1'b1;
      step(3);
      evt_ready[1] = 1'b0;
      chk("mid_valid", 32'(evt_valid[1]), 32'd1);
      chk("mid_ovf", 32'(overflow[1]), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(evt_valid), 32'h0);
      chk("mid_rst_ovf", 32'(overflow), 32'h0);
      step(2);
      chk("post_rst_e1", 32'(evt_valid), 32'h0);
      step();
      chk("post_rst_high", 32'(evt_valid), 32'h1);
      evt_ready = 4'hF;
      step();
      chk("post_rst_one", 32'(evt_valid), 32'h0);
      step(4);
      chk("post_rst_stale", 32'(evt_valid), 32'h0);
      evt_ready = '0;

      // Toggle mode: three transitions give three events
      for (int k = 0; k < 3; k++) begin
         b_in[0] = ~b_in[0];
         step(4);
      end
      chk("tog_ovf", 32'(b_ovf), 32'h0);
      b_ready[0] = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("tog_drain", 32'(b_valid), 32'h1);
         step();
      end
      chk("tog_empty", 32'(b_valid), 32'h0);
      b_ready[0] = 1'b0;

      // Three-stage synchroniser latency
      s_in[0] = 1'b1;
      step(3);
      chk("s3_e2", 32'(s_valid), 32'h0);
      step();
      chk("s3_e3", 32'(s_valid), 32'h1);
      s_ready[0] = 1'b1;
      step();
      chk("s3_empty", 32'(s_valid), 32'h0);
      s_ready[0] = 1'b0;

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
